// File: rtl/fetcher.sv
// Per-warp instruction fetch stage with a one-entry PC reuse buffer.
// Reads one word over a valid/ready handshake and holds it for decode.
package fetcher_pkg;
   typedef enum logic [2:0] {
      WARP_IDLE,
      WARP_FETCH,
      WARP_DECODE,
      WARP_REQUEST,
      WARP_WAIT,
      WARP_EXECUTE,
      WARP_UPDATE,
      WARP_DONE
   } warp_state_t;

   typedef logic [31:0] instruction_t;

   typedef enum logic [1:0] {
      FETCHER_IDLE     = 2'd0,
      FETCHER_FETCHING = 2'd1,
      FETCHER_DONE     = 2'd2
   } fetcher_state_t;
endpackage

module fetcher
   import fetcher_pkg::*;
#(
   parameter int ADDR_WIDTH  = 8,
   parameter int INSTR_WIDTH = 32,
   parameter int REUSE_EN    = 1,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  warp_state_t            warp_state,
   input  logic [ADDR_WIDTH-1:0]  pc,
   input  logic                   invalidate,
   output logic                   imem_read_valid,
   output logic [ADDR_WIDTH-1:0]  imem_read_address,
   input  logic                   imem_read_ready,
   input  logic [INSTR_WIDTH-1:0] imem_read_data,
   output logic [1:0]             fetcher_state,
   output logic [INSTR_WIDTH-1:0] instruction,
   output logic [CNT_WIDTH-1:0]   stall_cycles
);

   if (INSTR_WIDTH != $bits(instruction_t)) begin : g_width_chk
      $error("INSTR_WIDTH must match instruction_t");
   end

   fetcher_state_t state, state_nxt;

   logic                  buf_valid;
   logic [ADDR_WIDTH-1:0] buf_pc;
   logic                  fetch_req;
   logic                  hit;
   logic                  start_miss;
   logic                  complete;
   logic                  in_fetch;

   assign fetch_req = (warp_state == WARP_FETCH);
   // A pending invalidate forces a miss even if the PC matches.
   assign hit = (REUSE_EN != 0) && buf_valid
             && (buf_pc == pc) && !invalidate;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FETCHER_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         FETCHER_IDLE: begin
            if (fetch_req) begin
               state_nxt = hit ? FETCHER_DONE : FETCHER_FETCHING;
            end
         end
         FETCHER_FETCHING: begin
            if (imem_read_ready) begin
               state_nxt = FETCHER_DONE;
            end
         end
         FETCHER_DONE: begin
            if (!fetch_req) begin
               state_nxt = FETCHER_IDLE;
            end
         end
         default: state_nxt = FETCHER_IDLE;
      endcase
   end

   always_comb begin
      start_miss = 1'b0;
      complete   = 1'b0;
      in_fetch   = 1'b0;
      unique case (state)
         FETCHER_IDLE: begin
            start_miss = fetch_req && !hit;
         end
         FETCHER_FETCHING: begin
            in_fetch = 1'b1;
            complete = imem_read_ready;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         imem_read_valid   <= 1'b0;
         imem_read_address <= '0;
         instruction       <= '0;
         stall_cycles      <= '0;
         buf_valid         <= 1'b0;
         buf_pc            <= '0;
      end else begin
         if (start_miss) begin
            imem_read_valid   <= 1'b1;
            imem_read_address <= pc;
         end
         if (complete) begin
            imem_read_valid <= 1'b0;
            instruction     <= imem_read_data;
            buf_pc          <= imem_read_address;
            buf_valid       <= 1'b1;
         end
         // Invalidate wins over a fill in the same cycle.
         if (invalidate) begin
            buf_valid <= 1'b0;
         end
         if (in_fetch && (stall_cycles != {CNT_WIDTH{1'b1}})) begin
            stall_cycles <= stall_cycles + 1'b1;
         end
      end
   end

   assign fetcher_state = state;

endmodule

// File: tb/tb_fetcher.sv
// Scoreboard bench for fetcher: two instances, one with reuse off
// and a 4-bit stall counter to reach saturation quickly.
module tb_fetcher;
   import fetcher_pkg::*;

   typedef struct {
      logic [31:0] instr;
      int          stall;
      int          reqs;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   warp_state_t ws[2];
   logic [7:0]  pc_s[2];
   logic        inv[2];
   logic        rdy[2];
   logic [31:0] rdata[2];
   logic        vld[2];
   logic [7:0]  addr[2];
   logic [1:0]  fst[2];
   logic [31:0] instr[2];
   logic [15:0] st0;
   logic [3:0]  st1;

   exp_t q0[$];
   exp_t q1[$];
   int   errors = 0;
   int   checks = 0;
   int   reqs[2] = '{0, 0};
   logic prev_vld[2] = '{1'b0, 1'b0};
   logic [1:0] prev_st[2] = '{2'd0, 2'd0};

   fetcher #(
      .ADDR_WIDTH(8), .INSTR_WIDTH(32), .REUSE_EN(1), .CNT_WIDTH(16)
   ) u0 (
      .clk(clk), .reset(reset), .warp_state(ws[0]), .pc(pc_s[0]),
      .invalidate(inv[0]), .imem_read_valid(vld[0]),
      .imem_read_address(addr[0]), .imem_read_ready(rdy[0]),
      .imem_read_data(rdata[0]), .fetcher_state(fst[0]),
      .instruction(instr[0]), .stall_cycles(st0)
   );

   fetcher #(
      .ADDR_WIDTH(8), .INSTR_WIDTH(32), .REUSE_EN(0), .CNT_WIDTH(4)
   ) u1 (
      .clk(clk), .reset(reset), .warp_state(ws[1]), .pc(pc_s[1]),
      .invalidate(inv[1]), .imem_read_valid(vld[1]),
      .imem_read_address(addr[1]), .imem_read_ready(rdy[1]),
      .imem_read_data(rdata[1]), .fetcher_state(fst[1]),
      .instruction(instr[1]), .stall_cycles(st1)
   );

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int stall_of(int i);
      return (i == 0) ? int'(st0) : int'(st1);
   endfunction

   // Monitor: count request rises and score every entry into DONE.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin : mon
         exp_t e;
         bit   have;
         if (vld[i] === 1'b1 && prev_vld[i] !== 1'b1) begin
            reqs[i] <= reqs[i] + 1;
         end
         prev_vld[i] <= vld[i];
         prev_st[i]  <= fst[i];
         if (reset === 1'b0 && fst[i] === 2'd1) begin
            chk("warp_in_fetch", 32'(ws[i]), 32'(WARP_FETCH));
         end
         if (fst[i] === 2'd2 && prev_st[i] !== 2'd2) begin
            have = 1'b0;
            if (i == 0 && q0.size() > 0) begin
               e = q0.pop_front();
               have = 1'b1;
            end
            if (i == 1 && q1.size() > 0) begin
               e = q1.pop_front();
               have = 1'b1;
            end
            checks++;
            if (!have) begin
               errors++;
               $display("FAIL unexpected_done: inst %0d got DONE, expected none", i);
            end else begin
               chk("instruction", instr[i], e.instr);
               chk("stall_cycles", 32'(stall_of(i)), 32'(e.stall));
               chk("mem_requests", 32'(reqs[i]), 32'(e.reqs));
            end
         end
      end
   end

   task automatic fetch(int i, logic [7:0] p, bit miss, int dly,
                        logic [31:0] data, bit inv_rdy,
                        logic [31:0] e_instr, int e_stall, int e_reqs);
      exp_t e;
      int   n;
      e = '{e_instr, e_stall, e_reqs};
      if (i == 0) q0.push_back(e);
      else        q1.push_back(e);
      @(negedge clk);
      ws[i]   = WARP_FETCH;
      pc_s[i] = p;
      @(negedge clk);
      if (miss) begin
         n = 1;
         while (vld[i] !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
         end
         chk("req_latency", 32'(n), 32'd1);
         chk("req_address", 32'(addr[i]), 32'(p));
         repeat (dly - 1) @(negedge clk);
         chk("valid_held", 32'(vld[i]), 32'd1);
         chk("addr_held", 32'(addr[i]), 32'(p));
         rdy[i]   = 1'b1;
         rdata[i] = data;
         if (inv_rdy) inv[i] = 1'b1;
         @(negedge clk);
         rdy[i]   = 1'b0;
         inv[i]   = 1'b0;
         rdata[i] = 32'h0;
         chk("done_after_ready", 32'(fst[i]), 32'd2);
      end else begin
         chk("hit_latency", 32'(fst[i]), 32'd2);
      end
      n = 0;
      while (fst[i] !== 2'd2 && n < 50) begin
         @(negedge clk);
         n++;
      end
      ws[i] = WARP_DECODE;
      @(negedge clk);
      chk("back_to_idle", 32'(fst[i]), 32'd0);
      chk("valid_low", 32'(vld[i]), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 2; i++) begin
         ws[i]    = WARP_IDLE;
         pc_s[i]  = 8'h0;
         inv[i]   = 1'b0;
         rdy[i]   = 1'b0;
         rdata[i] = 32'h0;
      end
      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_state", 32'(fst[0]), 32'd0);
      chk("rst_valid", 32'(vld[0]), 32'd0);
      chk("rst_addr", 32'(addr[0]), 32'd0);
      chk("rst_instr", instr[0], 32'd0);
      chk("rst_stall", 32'(st0), 32'd0);
      reset = 1'b0;

      // Reset one cycle into FETCHING, then a late ready.
      @(negedge clk);
      ws[0]   = WARP_FETCH;
      pc_s[0] = 8'h09;
      @(negedge clk);
      chk("pre_rst_fetching", 32'(fst[0]), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_valid", 32'(vld[0]), 32'd0);
      chk("mid_rst_state", 32'(fst[0]), 32'd0);
      reset = 1'b0;
      ws[0] = WARP_DECODE;
      @(negedge clk);
      rdy[0]   = 1'b1;
      rdata[0] = 32'hDEADBEEF;
      @(negedge clk);
      rdy[0]   = 1'b0;
      rdata[0] = 32'h0;
      @(negedge clk);
      chk("late_ready_instr", instr[0], 32'd0);
      chk("late_ready_state", 32'(fst[0]), 32'd0);
      chk("late_ready_stall", 32'(st0), 32'd0);

      //   i  pc     miss dly data          inv  exp_instr     stall reqs
      fetch(0, 8'h05, 1, 3, 32'h00A00093, 0, 32'h00A00093, 3, 2);
      fetch(0, 8'h05, 0, 0, 32'h0,        0, 32'h00A00093, 3, 2);
      fetch(0, 8'h06, 1, 1, 32'h00100113, 0, 32'h00100113, 4, 3);
      fetch(0, 8'h05, 1, 2, 32'h00A00093, 0, 32'h00A00093, 6, 4);
      @(negedge clk);
      inv[0] = 1'b1;
      @(negedge clk);
      inv[0] = 1'b0;
      fetch(0, 8'h05, 1, 1, 32'h00200193, 0, 32'h00200193, 7, 5);
      fetch(0, 8'h07, 1, 2, 32'h12345678, 1, 32'h12345678, 9, 6);
      fetch(0, 8'h07, 1, 1, 32'h12345678, 0, 32'h12345678, 10, 7);
      fetch(0, 8'h07, 0, 0, 32'h0,        0, 32'h12345678, 10, 7);

      fetch(1, 8'h03, 1, 1,  32'hAAAA0001, 0, 32'hAAAA0001, 1, 1);
      fetch(1, 8'h03, 1, 1,  32'hAAAA0001, 0, 32'hAAAA0001, 2, 2);
      fetch(1, 8'h04, 1, 18, 32'hBBBB0002, 0, 32'hBBBB0002, 15, 3);

      // Spurious ready while idle must be ignored.
      @(negedge clk);
      rdy[1]   = 1'b1;
      rdata[1] = 32'hCCCC0003;
      @(negedge clk);
      rdy[1]   = 1'b0;
      rdata[1] = 32'h0;
      @(negedge clk);
      chk("idle_ready_state", 32'(fst[1]), 32'd0);
      chk("idle_ready_valid", 32'(vld[1]), 32'd0);
      chk("idle_ready_instr", instr[1], 32'hBBBB0002);
      chk("idle_ready_stall", 32'(st1), 32'hF);

      repeat (2) @(negedge clk);
      chk("q0_drained", 32'(q0.size()), 32'd0);
      chk("q1_drained", 32'(q1.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
